// File: rtl/dragon_move_scheduler.sv
// Per-frame movement sequencer for the dragon: paces step requests to the head
// datapath, commits the returned head, shifts body history, and tracks length/death.
module dragon_move_scheduler #(
  parameter int unsigned MovePeriod = 8,
  parameter int unsigned AckTimeout = 15,
  parameter int unsigned MaxLen     = 8,
  parameter int unsigned InitLen    = 3,
  parameter logic [7:0]  StartLoc   = 8'h77
) (
  input  logic       frame_clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       grow_i,
  input  logic       hurt_i,
  output logic       move_req_o,
  input  logic       move_ack_i,
  input  logic [7:0] next_location_i,
  input  logic [1:0] next_direction_i,
  output logic [7:0] head_location_o,
  output logic [1:0] head_direction_o,
  output logic [3:0] body_length_o,
  input  logic [3:0] segment_index_i,
  output logic [7:0] segment_location_o,
  output logic       segment_valid_o,
  output logic       move_done_o,
  output logic       ack_error_o,
  output logic       dead_o
);

  localparam logic [7:0] TickLast = 8'(MovePeriod - 1);
  localparam logic [7:0] AckLimit = 8'(AckTimeout);
  localparam logic [3:0] LenMax   = 4'(MaxLen);
  localparam logic [3:0] LenInit  = 4'(InitLen);
  localparam logic [1:0] DirRight = 2'd1;

  typedef enum logic [1:0] {StIdle, StWait, StReq, StDead} state_e;

  state_e     state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [7:0] to_q, to_d;
  logic [7:0] head_q;
  logic [1:0] dir_q;
  logic [3:0] len_q;
  logic [7:0] seg_q [MaxLen];
  logic       done_q, err_q, dead_q;
  logic       commit, timeout, kill;

  assign kill = hurt_i && !grow_i && (len_q == 4'd1) && (state_q != StDead);

  // State register
  always_ff @(posedge frame_clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      tick_q  <= 8'd0;
      to_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      to_q    <= to_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    to_d    = to_q;
    commit  = 1'b0;
    timeout = 1'b0;
    unique case (state_q)
      StIdle: begin
        tick_d = 8'd0;
        // The IDLE->WAIT cycle counts toward the period, so the first request
        // lands MovePeriod cycles after enable while steady state is MovePeriod+1.
        if (enable_i) begin
          state_d = StWait;
          tick_d  = 8'd1;
        end
      end
      StWait: begin
        if (!enable_i) begin
          state_d = StIdle;
          tick_d  = 8'd0;
        end else if (tick_q >= TickLast) begin
          state_d = StReq;
          tick_d  = 8'd0;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      StReq: begin
        if (move_ack_i) begin
          commit  = 1'b1;
          state_d = StWait;
          to_d    = 8'd0;
        end else if (to_q + 8'd1 >= AckLimit) begin
          timeout = 1'b1;
          state_d = StWait;
          to_d    = 8'd0;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      StDead: state_d = StDead;
      default: state_d = StIdle;
    endcase
    if (kill) begin
      state_d = StDead;
      commit  = 1'b0;
      timeout = 1'b0;
    end
  end

  // Datapath: head, body history, length, flags
  always_ff @(posedge frame_clk_i) begin
    if (!rst_ni) begin
      head_q <= StartLoc;
      dir_q  <= DirRight;
      len_q  <= LenInit;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      dead_q <= 1'b0;
      for (int i = 0; i < MaxLen; i++) seg_q[i] <= StartLoc;
    end else begin
      done_q <= commit;
      if (timeout) err_q <= 1'b1;
      if (commit) begin
        head_q   <= next_location_i;
        dir_q    <= next_direction_i;
        seg_q[0] <= head_q;
        for (int i = 1; i < MaxLen; i++) seg_q[i] <= seg_q[i-1];
      end
      if (state_q != StDead) begin
        if (grow_i && !hurt_i && (len_q < LenMax)) begin
          len_q <= len_q + 4'd1;
        end else if (hurt_i && !grow_i && (len_q != 4'd0)) begin
          len_q <= len_q - 4'd1;
          if (len_q == 4'd1) dead_q <= 1'b1;
        end
      end
    end
  end

  // Outputs
  always_comb begin
    move_req_o         = (state_q == StReq);
    segment_valid_o    = (segment_index_i < len_q);
    segment_location_o = 8'h00;
    for (int i = 0; i < MaxLen; i++) begin
      if (segment_valid_o && (segment_index_i == 4'(i))) segment_location_o = seg_q[i];
    end
  end

  assign head_location_o  = head_q;
  assign head_direction_o = dir_q;
  assign body_length_o    = len_q;
  assign move_done_o      = done_q;
  assign ack_error_o      = err_q;
  assign dead_o           = dead_q;

endmodule

// File: tb/tb_dragon_move_scheduler.sv
// Directed bench for dragon_move_scheduler with hand-computed expectations.
module tb_dragon_move_scheduler;

  logic       clk = 1'b0;
  logic       rst_n, enable, grow, hurt;
  logic       move_req, move_ack;
  logic [7:0] next_location;
  logic [1:0] next_direction;
  logic [7:0] head_location;
  logic [1:0] head_direction;
  logic [3:0] body_length;
  logic [3:0] segment_index;
  logic [7:0] segment_location;
  logic       segment_valid, move_done, ack_error, dead;

  logic ack_follow, ack_manual;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;
  logic seen_req;

  assign move_ack = ack_follow ? move_req : ack_manual;

  always #5 clk = ~clk;

  dragon_move_scheduler dut (
    .frame_clk_i       (clk),
    .rst_ni            (rst_n),
    .enable_i          (enable),
    .grow_i            (grow),
    .hurt_i            (hurt),
    .move_req_o        (move_req),
    .move_ack_i        (move_ack),
    .next_location_i   (next_location),
    .next_direction_i  (next_direction),
    .head_location_o   (head_location),
    .head_direction_o  (head_direction),
    .body_length_o     (body_length),
    .segment_index_i   (segment_index),
    .segment_location_o(segment_location),
    .segment_valid_o   (segment_valid),
    .move_done_o       (move_done),
    .ack_error_o       (ack_error),
    .dead_o            (dead)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic seg_chk(input string tag, input logic [3:0] idx, input logic v,
                         input logic [7:0] loc);
    segment_index = idx;
    #1;
    chk({tag, "_valid"}, 16'(segment_valid), 16'(v));
    chk({tag, "_loc"}, 16'(segment_location), 16'(loc));
  endtask

  // Ticks until move_req is high; count compared by caller (bounded)
  task automatic wait_req(output int cnt);
    cnt = 0;
    while (!move_req && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic pulse(input logic g, input logic h);
    grow = g;
    hurt = h;
    tick();
    grow = 1'b0;
    hurt = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; grow = 1'b0; hurt = 1'b0;
    ack_follow = 1'b0; ack_manual = 1'b0;
    next_location = 8'h00; next_direction = 2'd0; segment_index = 4'd0;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_head", 16'(head_location), 16'h77);
    chk("rst_dir", 16'(head_direction), 16'd1);
    chk("rst_len", 16'(body_length), 16'd3);
    chk("rst_req", 16'(move_req), 16'd0);
    chk("rst_flags", {13'd0, move_done, ack_error, dead}, 16'd0);
    seg_chk("rst_seg2", 4'd2, 1'b1, 8'h77);
    seg_chk("rst_seg3", 4'd3, 1'b0, 8'h00);

    // First move with ack tied to req
    enable = 1'b1; ack_follow = 1'b1; next_location = 8'h78; next_direction = 2'd2;
    wait_req(n);
    chk("first_req_latency", 16'(n), 16'd8);
    chk("pre_commit_head", 16'(head_location), 16'h77);
    tick();
    chk("c1_head", 16'(head_location), 16'h78);
    chk("c1_dir", 16'(head_direction), 16'd2);
    chk("c1_done", 16'(move_done), 16'd1);
    chk("c1_req_low", 16'(move_req), 16'd0);
    seg_chk("c1_seg0", 4'd0, 1'b1, 8'h77);
    next_location = 8'h79;
    wait_req(n);
    chk("c1_done_pulse", 16'(move_done), 16'd0);
    chk("steady_latency", 16'(n), 16'd8);
    tick();
    next_location = 8'h7A;
    wait_req(n);
    chk("steady_latency2", 16'(n), 16'd8);
    tick();
    chk("c3_head", 16'(head_location), 16'h7A);
    seg_chk("c3_seg0", 4'd0, 1'b1, 8'h79);
    seg_chk("c3_seg1", 4'd1, 1'b1, 8'h78);
    seg_chk("c3_seg2", 4'd2, 1'b1, 8'h77);
    seg_chk("c3_seg3", 4'd3, 1'b0, 8'h00);

    // Ack timeout
    ack_follow = 1'b0; ack_manual = 1'b0;
    wait_req(n);
    chk("to_req_latency", 16'(n), 16'd8);
    n = 0;
    while (move_req && n < 40) begin
      tick();
      n++;
    end
    chk("to_req_width", 16'(n), 16'd15);
    chk("to_err", 16'(ack_error), 16'd1);
    chk("to_head", 16'(head_location), 16'h7A);
    chk("to_no_done", 16'(move_done), 16'd0);
    ack_follow = 1'b1; next_location = 8'h7B;
    wait_req(n);
    chk("after_to_latency", 16'(n), 16'd8);
    tick();
    chk("c4_head", 16'(head_location), 16'h7B);
    chk("err_sticky", 16'(ack_error), 16'd1);

    // Growth saturates; history revealed
    for (int i = 0; i < 6; i++) pulse(1'b1, 1'b0);
    chk("grow_sat", 16'(body_length), 16'd8);
    pulse(1'b1, 1'b1);
    chk("grow_hurt", 16'(body_length), 16'd8);
    seg_chk("grown_seg3", 4'd3, 1'b1, 8'h77);
    seg_chk("grown_seg7", 4'd7, 1'b1, 8'h77);
    seg_chk("grown_seg8", 4'd8, 1'b0, 8'h00);

    // Shrink to death
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b1);
    chk("shrink_len", 16'(body_length), 16'd3);
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk("len1", 16'(body_length), 16'd1);
    chk("alive", 16'(dead), 16'd0);
    pulse(1'b0, 1'b1);
    chk("dead_len", 16'(body_length), 16'd0);
    chk("dead_flag", 16'(dead), 16'd1);
    chk("dead_req", 16'(move_req), 16'd0);
    ack_follow = 1'b0; ack_manual = 1'b1; next_location = 8'h11;
    pulse(1'b1, 1'b0);
    seen_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (move_req) seen_req = 1'b1;
    end
    chk("dead_no_req", 16'(seen_req), 16'd0);
    chk("dead_len_frozen", 16'(body_length), 16'd0);
    chk("dead_head_frozen", 16'(head_location), 16'h7B);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rerst_len", 16'(body_length), 16'd3);
    chk("rerst_dead", 16'(dead), 16'd0);
    chk("rerst_head", 16'(head_location), 16'h77);
    chk("rerst_err", 16'(ack_error), 16'd0);

    // Enable dropped mid-handshake
    ack_manual = 1'b0;
    wait_req(n);
    chk("re_latency", 16'(n), 16'd8);
    enable = 1'b0;
    tick(); tick(); tick();
    chk("hold_req", 16'(move_req), 16'd1);
    ack_manual = 1'b1; next_location = 8'h55;
    tick();
    ack_manual = 1'b0;
    chk("drop_commit", 16'(head_location), 16'h55);
    chk("drop_req_low", 16'(move_req), 16'd0);
    seen_req = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (move_req) seen_req = 1'b1;
    end
    chk("parked", 16'(seen_req), 16'd0);
    enable = 1'b1;
    wait_req(n);
    chk("resume_latency", 16'(n), 16'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
